panel_ctrl: RTL

PANEL_CTRL -- requirements
Module: panel_ctrl

---
 rtl/panel_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/panel_ctrl.sv
// Front-panel controller. It synchronizes and debounces the five panel switches
// and turns each accepted rising edge into a one-cycle event. A small FSM then
// gates the CPU microcycle enable for RUN, HALT, single-microcycle step,
// single-instruction step and a timed CLEAR pulse.
//
// Ports:
//   SYSCLK, RESET_n             clock, asynchronous active-low reset
//   sw_CLEAR/RUN/HALT/STEPM/STEPI  raw bouncy panel switches (active-high)
//   cycleDone, instDone, hltExec   one-cycle status pulses from the CPU
//   pClear, pMcEnable, pRunning    registered CPU controls / RUN lamp
//   pState                         registered state code
module panel_ctrl #(
  parameter int unsigned DEBOUNCE     = 16,
  parameter int unsigned CLEAR_CYCLES = 4
) (
  input  logic       SYSCLK,
  input  logic       RESET_n,
  input  logic       sw_CLEAR,
  input  logic       sw_RUN,
  input  logic       sw_HALT,
  input  logic       sw_STEPM,
  input  logic       sw_STEPI,
  input  logic       cycleDone,
  input  logic       instDone,
  input  logic       hltExec,
  output logic       pClear,
  output logic       pMcEnable,
  output logic       pRunning,
  output logic [2:0] pState
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRun     = 3'd1,
    StHalting = 3'd2,
    StStepm   = 3'd3,
    StStepi   = 3'd4,
    StClr     = 3'd5
  } state_e;

  localparam logic [15:0] DbLast  = 16'(DEBOUNCE - 1);
  localparam logic [7:0]  ClrLoad = 8'(CLEAR_CYCLES - 1);

  // Bit order doubles as priority order: lower index wins.
  logic [4:0] sw_raw;
  assign sw_raw = {sw_STEPM, sw_STEPI, sw_RUN, sw_HALT, sw_CLEAR};

  logic [4:0]  sync1_q, sync2_q, acc_q, acc_dly_q, ev_q;
  logic [15:0] cnt_q [5];

  always_ff @(posedge SYSCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      acc_q     <= '0;
      acc_dly_q <= '0;
      ev_q      <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= sw_raw;
      sync2_q   <= sync1_q;
      acc_dly_q <= acc_q;
      ev_q      <= acc_q & ~acc_dly_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == acc_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DbLast) begin
          cnt_q[i] <= '0;
          acc_q[i] <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // CLEAR is handled before the case, so only the lower events need masking.
  logic ev_clear, ev_halt, ev_run, ev_stepi, ev_stepm;
  assign ev_clear = ev_q[0];
  assign ev_halt  = ev_q[1];
  assign ev_run   = ev_q[2] & ~ev_q[1];
  assign ev_stepi = ev_q[3] & ~|ev_q[2:1];
  assign ev_stepm = ev_q[4] & ~|ev_q[3:1];

  state_e     state_q, state_d;
  logic [7:0] clr_q, clr_d;

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (ev_clear) begin
      state_d = StClr;
      clr_d   = ClrLoad;
    end else begin
      case (state_q)
        StIdle: begin
          if (ev_run)        state_d = StRun;
          else if (ev_stepi) state_d = StStepi;
          else if (ev_stepm) state_d = StStepm;
        end
        StRun: begin
          if (hltExec)      state_d = StIdle;
          else if (ev_halt) state_d = StHalting;
        end
        StHalting: if (instDone || hltExec) state_d = StIdle;
        StStepm:   if (ev_halt || cycleDone) state_d = StIdle;
        StStepi:   if (ev_halt || instDone) state_d = StIdle;
        StClr: begin
          if (clr_q == 8'd0) state_d = StIdle;
          else               clr_d   = clr_q - 8'd1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with pState.
  logic clear_d, mc_d, run_d;
  always_comb begin
    clear_d = (state_d == StClr);
    mc_d    = (state_d == StRun) || (state_d == StHalting) ||
              (state_d == StStepm) || (state_d == StStepi);
    run_d   = (state_d == StRun) || (state_d == StHalting);
  end

  always_ff @(posedge SYSCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= StIdle;
      clr_q     <= '0;
      pClear    <= 1'b0;
      pMcEnable <= 1'b0;
      pRunning  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      pClear    <= clear_d;
      pMcEnable <= mc_d;
      pRunning  <= run_d;
    end
  end

  assign pState = state_q;

endmodule
